// File: rtl/audio_pkg.sv
// Shared audio datapath types and widths for the output end of the effect chain.
package audio_pkg;

    localparam int SAMPLE_WIDTH = 24;
    localparam int SLOT_WIDTH   = 32;
    localparam int FRAME_BITS   = 2 * SLOT_WIDTH;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides system_clock down to BCLK and flags the cycle
// at whose end BCLK is about to rise or fall.
module i2s_bclk_gen #(
    parameter int BCLK_HALF_DIV = 16
) (
    input  logic system_clock,
    input  logic rst,
    output logic bclk,
    output logic rise_evt,
    output logic fall_evt
);

    localparam int DW = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic          term;

    // Half-period counter; BCLK toggles when the counter wraps.
    always_comb begin
        term      = (div_cnt_q == DIV_LAST);
        div_cnt_d = term ? '0 : div_cnt_q + 1'b1;
        bclk_d    = term ? ~bclk_q : bclk_q;
    end

    // Divider state, cleared so BCLK restarts low after reset.
    always_ff @(posedge system_clock) begin
        if (rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk     = bclk_q;
    assign rise_evt = term & ~bclk_q;
    assign fall_evt = term & bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers the latest filter result, loads it once per frame
// and shifts it out MSB first on both channel slots, one BCLK after LRCLK.
module i2s_tx #(
    parameter int SAMPLE_WIDTH  = audio_pkg::SAMPLE_WIDTH,
    parameter int SLOT_WIDTH    = audio_pkg::SLOT_WIDTH,
    parameter int BCLK_HALF_DIV = 16
) (
    input  logic                           system_clock,
    input  logic                           rst,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_valid,
    input  logic                           clear_flags,
    output logic                           i2s_bclk,
    output logic                           i2s_lrclk,
    output logic                           i2s_sdata,
    output logic                           frame_start,
    output logic                           underrun,
    output logic                           overrun
);

    import audio_pkg::*;

    localparam int FRAME = 2 * SLOT_WIDTH;
    localparam int BCW   = $clog2(FRAME);
    localparam int IDXW  = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(FRAME - 1);
    localparam logic [BCW-1:0] SLOT_LEN  = BCW'(SLOT_WIDTH);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(SAMPLE_WIDTH);

    logic fall_evt;
    logic unused_rise_evt;

    logic signed [SAMPLE_WIDTH-1:0] holding_q, holding_d;
    logic signed [SAMPLE_WIDTH-1:0] shadow_q, shadow_d;
    logic [BCW-1:0]                 bit_cnt_q, bit_cnt_d;
    logic                           fresh_q, fresh_d;
    logic                           primed_q, primed_d;
    logic                           lrclk_q, lrclk_d;
    logic                           sdata_q, sdata_d;
    logic                           frame_start_q, frame_start_d;
    logic                           underrun_q, underrun_d;
    logic                           overrun_q, overrun_d;

    logic [BCW-1:0]  bit_nxt;
    logic [BCW-1:0]  pos;
    logic [IDXW-1:0] idx;
    logic            frame_load;

    i2s_bclk_gen #(
        .BCLK_HALF_DIV(BCLK_HALF_DIV)
    ) u_bclk_gen (
        .system_clock(system_clock),
        .rst         (rst),
        .bclk        (i2s_bclk),
        .rise_evt    (unused_rise_evt),
        .fall_evt    (fall_evt)
    );

    // Next-state logic: input capture, frame load, serializer and sticky flags.
    always_comb begin
        holding_d     = holding_q;
        shadow_d      = shadow_q;
        bit_cnt_d     = bit_cnt_q;
        fresh_d       = fresh_q;
        primed_d      = primed_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = clear_flags ? 1'b0 : underrun_q;
        overrun_d     = clear_flags ? 1'b0 : overrun_q;

        bit_nxt    = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        frame_load = fall_evt && (bit_nxt == '0);
        pos        = (bit_nxt >= SLOT_LEN) ? bit_nxt - SLOT_LEN : bit_nxt;
        idx        = IDXW'(SAMPLE_WIDTH) - IDXW'(pos);

        // A new sample outside a frame load waits in holding; a second one
        // before consumption overwrites it and is reported.
        if (sample_valid) begin
            holding_d = sample_in;
            primed_d  = 1'b1;
            if (!frame_load) begin
                fresh_d = 1'b1;
                if (fresh_q) begin
                    overrun_d = 1'b1;
                end
            end
        end

        // Frame load: a sample arriving on this very cycle bypasses holding.
        if (frame_load) begin
            frame_start_d = 1'b1;
            fresh_d       = 1'b0;
            if (sample_valid) begin
                shadow_d = sample_in;
            end else begin
                shadow_d = holding_q;
                if (!fresh_q && primed_q) begin
                    underrun_d = 1'b1;
                end
            end
        end

        // Outputs move only on BCLK falling so the DAC samples on rising.
        if (fall_evt) begin
            bit_cnt_d = bit_nxt;
            lrclk_d   = (bit_nxt >= SLOT_LEN);
            if ((pos != '0) && (pos <= DATA_LAST)) begin
                sdata_d = shadow_q[idx];
            end else begin
                sdata_d = 1'b0;
            end
        end
    end

    // State registers; reset aborts any frame in progress.
    always_ff @(posedge system_clock) begin
        if (rst) begin
            holding_q     <= '0;
            shadow_q      <= '0;
            bit_cnt_q     <= BIT_LAST;
            fresh_q       <= 1'b0;
            primed_q      <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            holding_q     <= holding_d;
            shadow_q      <= shadow_d;
            bit_cnt_q     <= bit_cnt_d;
            fresh_q       <= fresh_d;
            primed_q      <= primed_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    assign i2s_lrclk   = lrclk_q;
    assign i2s_sdata   = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with BCLK_HALF_DIV=2 (BCLK = 4 cycles, frame = 256 cycles).
module tb_i2s_tx;

    localparam int SW       = 24;
    localparam int FRAME_CY = 256;

    logic                 system_clock = 1'b0;
    logic                 rst;
    logic signed [SW-1:0] sample_in;
    logic                 sample_valid;
    logic                 clear_flags;
    logic                 i2s_bclk;
    logic                 i2s_lrclk;
    logic                 i2s_sdata;
    logic                 frame_start;
    logic                 underrun;
    logic                 overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] exp_data;
        logic        exp_under;
        logic        exp_over;
        logic        clr;
        logic        use1;
        logic [23:0] s1;
        logic        use2;
        logic [23:0] s2;
        logic        byp;
        logic [23:0] sb;
    } vec_t;

    vec_t vecs [5];

    i2s_tx #(
        .SAMPLE_WIDTH (24),
        .SLOT_WIDTH   (32),
        .BCLK_HALF_DIV(2)
    ) dut (
        .system_clock(system_clock),
        .rst         (rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .clear_flags (clear_flags),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata),
        .frame_start (frame_start),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    always #5 system_clock = ~system_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected bit stream of one frame, bit k = value captured at the k-th BCLK rise.
    function automatic logic [63:0] exp_bits(input logic [23:0] data);
        logic [63:0] r;
        int p;
        r = '0;
        for (int k = 0; k < 64; k++) begin
            p = k % 32;
            if (p >= 1 && p <= 24) r[k] = data[24 - p];
        end
        return r;
    endfunction

    // Runs one full frame from a frame_start observation, capturing on BCLK rising
    // and driving this vector's inputs at fixed cycle offsets.
    task automatic run_frame(input vec_t v, output logic [63:0] dat, output logic [63:0] lrv,
                             output int rises);
        logic prev;
        prev  = i2s_bclk;
        rises = 0;
        dat   = '0;
        lrv   = '0;
        for (int c = 1; c <= FRAME_CY; c++) begin
            tick();
            if (c == 1) check("frame_start_width", frame_start, 0);
            if (v.clr && c == 4) begin
                check("clear_underrun", underrun, 0);
                check("clear_overrun", overrun, 0);
            end
            if (!prev && i2s_bclk) begin
                if (rises < 64) begin
                    dat[rises] = i2s_sdata;
                    lrv[rises] = i2s_lrclk;
                end
                rises++;
            end
            prev = i2s_bclk;
            sample_valid = 1'b0;
            clear_flags  = 1'b0;
            if (v.clr && c == 2) clear_flags = 1'b1;
            if (v.use1 && c == 10) begin sample_valid = 1'b1; sample_in = v.s1; end
            if (v.use2 && c == 20) begin sample_valid = 1'b1; sample_in = v.s2; end
            if (v.byp && c == FRAME_CY - 1) begin sample_valid = 1'b1; sample_in = v.sb; end
        end
    endtask

    initial begin
        logic [63:0] dat, lrv, eb;
        int          rises;
        vec_t        none;

        //          exp_data     u     o     clr   use1  s1           use2  s2           byp   sb
        vecs[0] = '{24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 24'hA5C3F0, 1'b0, 24'h000000, 1'b0, 24'h000000};
        vecs[1] = '{24'hA5C3F0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 24'h000000, 1'b0, 24'h000000};
        vecs[2] = '{24'hA5C3F0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000001, 1'b1, 24'h7FFFFF, 1'b0, 24'h000000};
        vecs[3] = '{24'h7FFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 24'h000000, 1'b1, 24'h800000};
        vecs[4] = '{24'h800000, 1'b0, 1'b0, 1'b0, 1'b1, 24'h7FFFFF, 1'b0, 24'h000000, 1'b0, 24'h000000};
        none    = '{24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 24'h000000, 1'b0, 24'h000000};

        rst          = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        clear_flags  = 1'b0;
        repeat (3) tick();
        check("rst_bclk", i2s_bclk, 0);
        check("rst_lrclk", i2s_lrclk, 0);
        check("rst_sdata", i2s_sdata, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_underrun", underrun, 0);
        check("rst_overrun", overrun, 0);

        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("first_fall_early", frame_start, 0);
            if (i == 2) check("first_rise", i2s_bclk, 1);
        end
        tick();
        check("first_frame_start", frame_start, 1);
        check("first_fall_bclk", i2s_bclk, 0);

        for (int v = 0; v < 5; v++) begin
            check($sformatf("v%0d_underrun", v), underrun, vecs[v].exp_under);
            check($sformatf("v%0d_overrun", v), overrun, vecs[v].exp_over);
            run_frame(vecs[v], dat, lrv, rises);
            eb = exp_bits(vecs[v].exp_data);
            check($sformatf("v%0d_rises", v), 64'(rises), 64);
            check($sformatf("v%0d_left_data", v), {32'h0, dat[31:0]}, {32'h0, eb[31:0]});
            check($sformatf("v%0d_right_data", v), {32'h0, dat[63:32]}, {32'h0, eb[63:32]});
            check($sformatf("v%0d_lrclk", v), lrv, 64'hFFFF_FFFF_0000_0000);
            check($sformatf("v%0d_frame_period", v), frame_start, 1);
        end

        // Frame carrying 7FFFFF: reset in the middle of left-slot bit 10.
        check("f5_underrun", underrun, 0);
        check("f5_overrun", overrun, 0);
        for (int c = 1; c <= 40; c++) tick();
        check("pre_reset_sdata", i2s_sdata, 1);
        rst          = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 24'h123456;
        tick();
        check("mid_rst_sdata", i2s_sdata, 0);
        check("mid_rst_lrclk", i2s_lrclk, 0);
        check("mid_rst_bclk", i2s_bclk, 0);
        repeat (2) tick();
        rst          = 1'b0;
        sample_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("restart_early", frame_start, 0);
        end
        tick();
        check("restart_frame_start", frame_start, 1);
        check("restart_underrun", underrun, 0);
        run_frame(none, dat, lrv, rises);
        check("restart_left_data", {32'h0, dat[31:0]}, 64'h0);
        check("restart_right_data", {32'h0, dat[63:32]}, 64'h0);
        check("restart_lrclk", lrv, 64'hFFFF_FFFF_0000_0000);
        check("restart_next_frame", frame_start, 1);
        check("restart_no_underrun", underrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
